asr_shift_seq: RTL and testbench

Iterative arithmetic right shifter that time-multiplexes a set of power-of-two sign-filling shift stages, applying one stage per cycle under a small FSM. It accepts one operand/amount pair over a valid/ready handshake, walks the shift amount MSB-first through the stages, and returns the result over a second valid/ready handshake. It is the sequenced alternative to a fully unrolled barrel shifter in the arithmetic datapath, trading latency for area.

---
 rtl/asr_shift_seq_if.sv | 27 ++
 rtl/asr_shift_seq.sv | 118 +++++++++++
 tb/tb_asr_shift_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asr_shift_seq_if.sv
// asr_shift_seq_if: operand/result handshake bundle for the sequenced
// arithmetic right shifter. The master side presents operand pairs and
// consumes results; the slave side is the shifter itself.
interface asr_shift_seq_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned AMTW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMTW-1:0]  in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/asr_shift_seq.sv
// asr_shift_seq: iterative arithmetic right shifter. One power-of-two
// sign-filling stage is applied per cycle, walking the amount MSB-first.
// Build option: define ASR_SHIFT_SEQ_SKIP_EN to visit only the set bits of
// the amount (latency 1+popcount instead of a fixed AMTW+1).
module asr_shift_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    asr_shift_seq_if.slave bus
);
    localparam int unsigned AMTW = $clog2(WIDTH);
    localparam int unsigned SW   = $clog2(AMTW);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [AMTW-1:0]  amt;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
`ifndef ASR_SHIFT_SEQ_SKIP_EN
    logic [SW-1:0]    stage;
`endif

    logic [SW-1:0]    stage_sel;
    logic [AMTW-1:0]  stage_bit;
    logic [WIDTH-1:0] shifted;
    logic             last_stage;
    logic             accept;

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign accept        = bus.in_valid && bus.in_ready;

    // Select the active stage and form the data after applying it.
    // The stage's bit weight in amt equals its shift distance, so stage_bit
    // serves both as the amt mask and as the shift count.
    always_comb begin
`ifdef ASR_SHIFT_SEQ_SKIP_EN
        stage_sel = '0;
        for (int unsigned i = 0; i < AMTW; i++) begin
            if (amt[i]) stage_sel = SW'(i);
        end
`else
        stage_sel = stage;
`endif
        stage_bit = AMTW'(1) << stage_sel;
        if ((amt & stage_bit) != '0) shifted = $signed(data) >>> stage_bit;
        else                         shifted = data;
`ifdef ASR_SHIFT_SEQ_SKIP_EN
        last_stage = ((amt & ~stage_bit) == '0);
`else
        last_stage = (stage == '0);
`endif
    end

    // Control FSM with registered result outputs; an accept in DONE
    // coincides with the retire, so it is handled ahead of the state case.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            data      <= '0;
            amt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifndef ASR_SHIFT_SEQ_SKIP_EN
            stage     <= '0;
`endif
        end else if (accept) begin
            data <= bus.in_data;
            amt  <= bus.in_amt;
`ifdef ASR_SHIFT_SEQ_SKIP_EN
            if (bus.in_amt == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out_data  <= bus.in_data;
            end else begin
                state     <= SHIFT;
                out_valid <= 1'b0;
            end
`else
            stage     <= SW'(AMTW - 1);
            state     <= SHIFT;
            out_valid <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    data <= shifted;
`ifdef ASR_SHIFT_SEQ_SKIP_EN
                    amt  <= amt & ~stage_bit;
`else
                    stage <= stage - SW'(1);
`endif
                    if (last_stage) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= shifted;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_asr_shift_seq.sv
// tb_asr_shift_seq: self-checking bench for asr_shift_seq against a
// signed-shift reference and a result queue.
module tb_asr_shift_seq;
    localparam int unsigned W    = 16;
    localparam int unsigned AMTW = $clog2(W);

    logic clk;
    logic reset;
    int   total;
    int   bad;

    asr_shift_seq_if #(.WIDTH(W)) bus ();

    asr_shift_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_asr(input logic [W-1:0] d, input logic [AMTW-1:0] a);
        int v;
        v = int'($signed(d));
        v = v >>> a;
        return v[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [AMTW-1:0] a);
`ifdef ASR_SHIFT_SEQ_SKIP_EN
        return 1 + $countones(a);
`else
        return AMTW + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with out_ready high; checks result and latency.
    task automatic run_op(input logic [W-1:0] d, input logic [AMTW-1:0] a, input string nm);
        int lat;
        logic [W-1:0] e;
        e = ref_asr(d, a);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = a;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready before accept: got %b want 1", nm, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_amt   = AMTW'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (bus.out_data !== e) begin
            bad++;
            $display("FAIL %s data: got %h want %h", nm, bus.out_data, e);
        end
        total++;
        if (lat != exp_lat(a)) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat(a));
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s retire: got valid=%b busy=%b want 0 0", nm, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        total++;
        if (bus.out_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0000", bus.out_data);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0]    d [5];
        logic [AMTW-1:0] a [5];
        logic [W-1:0]    e [5];
        logic [W-1:0]    r;
        d = '{16'h8001, 16'h8000, 16'h7FFF, 16'h1234, 16'hABCD};
        a = '{4'd8, 4'd15, 4'd15, 4'd5, 4'd0};
        e = '{16'hFF80, 16'hFFFF, 16'h0000, 16'h0091, 16'hABCD};
        for (int i = 0; i < 5; i++) begin
            r = ref_asr(d[i], a[i]);
            total++;
            if (r !== e[i]) begin
                bad++;
                $display("FAIL directed_model%0d: got %h want %h", i, r, e[i]);
            end
            run_op(d[i], a[i], $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_amt    = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            bus.in_amt   = AMTW'($urandom);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0091 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure%0d: got valid=%b data=%h ready=%b want 1 0091 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_retire: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]    d [3];
        logic [AMTW-1:0] a [3];
        int nacc;
        int nret;
        int last_ret;
        bit acc;
        bit ret;
        d = '{16'hF00F, 16'h4321, 16'h8888};
        a = '{4'd3, 4'd9, 4'd14};
        nacc = 0;
        nret = 0;
        last_ret = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d[0];
        bus.in_amt    = a[0];
        for (int c = 0; c < 100 && nret < 3; c++) begin
            #1;
            acc = bus.in_valid && bus.in_ready;
            ret = bus.out_valid && bus.out_ready;
            if (nacc > 0) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_busy cycle %0d: got %b want 1", c, bus.busy);
                end
            end
            if (ret) begin
                total++;
                if (bus.out_data !== ref_asr(d[nret], a[nret])) begin
                    bad++;
                    $display("FAIL b2b_data%0d: got %h want %h", nret, bus.out_data, ref_asr(d[nret], a[nret]));
                end
                if (nret > 0) begin
                    total++;
                    if (c - last_ret != exp_lat(a[nret])) begin
                        bad++;
                        $display("FAIL b2b_gap%0d: got %0d want %0d", nret, c - last_ret, exp_lat(a[nret]));
                    end
                end
                if (nret < 2) begin
                    total++;
                    if (!acc) begin
                        bad++;
                        $display("FAIL b2b_coincide%0d: got accept=0 want 1", nret);
                    end
                end
                last_ret = c;
                nret++;
            end
            if (acc) nacc++;
            tick();
            if (nacc < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = d[nacc];
                bus.in_amt   = a[nacc];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        total++;
        if (nret != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 3", nret);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h8000;
        bus.in_amt    = 4'd15;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_busy: got %b want 1", bus.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: got ready=%b data=%h valid=%b busy=%b want 1 0000 0 0",
                     bus.in_ready, bus.out_data, bus.out_valid, bus.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL midreset_novalid: got valid=1 want 0");
        end
        run_op(16'h8000, 4'd15, "after_reset");
    endtask

    task automatic test_random();
        localparam int N = 4000;
        logic [W-1:0] q[$];
        logic [W-1:0] e;
        int nacc;
        int nret;
        bit acc;
        nacc = 0;
        nret = 0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 90000 && nret < N; c++) begin
            if (!bus.in_valid && nacc < N && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = W'($urandom);
                bus.in_amt   = AMTW'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: got result %h want none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    if (bus.out_data !== e) begin
                        bad++;
                        $display("FAIL rand_data%0d: got %h want %h", nret, bus.out_data, e);
                    end
                end
                nret++;
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                q.push_back(ref_asr(bus.in_data, bus.in_amt));
                nacc++;
            end
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        total++;
        if (nret != N || q.size() != 0) begin
            bad++;
            $display("FAIL rand_count: got retired=%0d pending=%0d want %0d 0", nret, q.size(), N);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
